// File: rtl/fifo_burst_reader.sv
// ============================================================================
// Module   : fifo_burst_reader
// Brief    : Pops a fixed-length burst from a FIFO read port and forwards it
//            on a valid/ready stream through a 2-entry skid buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_burst_reader #(
   parameter int DATA_LEN = 32,
   parameter int BURST_W  = 8,
   parameter int WAIT_W   = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start_i,
   input  logic [BURST_W-1:0]  burst_len_i,
   output logic                busy_o,
   output logic                done_o,
   input  logic                rempty_i,
   input  logic [DATA_LEN-1:0] rdata_i,
   output logic                rincr_o,
   output logic [DATA_LEN-1:0] m_data_o,
   output logic                m_last_o,
   output logic                m_valid_o,
   input  logic                m_ready_i,
   output logic [WAIT_W-1:0]   wait_cnt_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [WAIT_W-1:0]  c_wait_max = '1;
   localparam logic [BURST_W-1:0] c_one      = BURST_W'(1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [BURST_W-1:0]  r_remaining;
   logic [1:0]          r_cnt;
   logic [1:0]          w_cnt_nxt;
   logic [DATA_LEN-1:0] r_head_data;
   logic                r_head_last;
   logic [DATA_LEN-1:0] r_tail_data;
   logic                r_tail_last;
   logic [WAIT_W-1:0]   r_wait_cnt;
   logic                w_push;
   logic                w_pop;
   logic                w_in_last;
   logic                w_accept;

   // A pop is the only way a word enters the skid buffer.
   assign w_push    = (r_state == S_RUN) && !rempty_i && (r_remaining != '0) && (r_cnt != 2'd2);
   assign w_pop     = (r_cnt != 2'd0) && m_ready_i;
   assign w_in_last = (r_remaining == c_one);
   assign w_accept  = (r_state == S_IDLE) && start_i;

   always_comb begin
      w_cnt_nxt = r_cnt;
      if (w_push && !w_pop) begin
         w_cnt_nxt = r_cnt + 2'd1;
      end else if (!w_push && w_pop) begin
         w_cnt_nxt = r_cnt - 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (start_i) begin
               w_state_nxt = (burst_len_i != '0) ? S_RUN : S_DONE;
            end
         end
         S_RUN: begin
            if (w_push && w_in_last) begin
               w_state_nxt = (w_cnt_nxt == 2'd0) ? S_DONE : S_DRAIN;
            end
         end
         S_DRAIN: begin
            if ((r_cnt == 2'd1) && w_pop && !w_push) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_remaining <= '0;
         r_wait_cnt  <= '0;
      end else begin
         if (w_accept) begin
            r_remaining <= burst_len_i;
         end else if (w_push) begin
            r_remaining <= r_remaining - c_one;
         end
         // Stall count survives the burst so software can read it afterwards.
         if (w_accept) begin
            r_wait_cnt <= '0;
         end else if ((r_state == S_RUN) && (r_remaining != '0) && rempty_i &&
                      (r_wait_cnt != c_wait_max)) begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= 2'd0;
         r_head_data <= '0;
         r_head_last <= 1'b0;
         r_tail_data <= '0;
         r_tail_last <= 1'b0;
      end else begin
         r_cnt <= w_cnt_nxt;
         // Push together with pop only happens at cnt==1, so the new word
         // becomes head directly; otherwise the tail slides forward.
         if (w_pop) begin
            if (w_push) begin
               r_head_data <= rdata_i;
               r_head_last <= w_in_last;
            end else begin
               r_head_data <= r_tail_data;
               r_head_last <= r_tail_last;
            end
         end else if (w_push) begin
            if (r_cnt == 2'd0) begin
               r_head_data <= rdata_i;
               r_head_last <= w_in_last;
            end else begin
               r_tail_data <= rdata_i;
               r_tail_last <= w_in_last;
            end
         end
      end
   end

   assign busy_o     = (r_state != S_IDLE);
   assign done_o     = (r_state == S_DONE);
   assign rincr_o    = w_push;
   assign m_valid_o  = (r_cnt != 2'd0);
   assign m_data_o   = r_head_data;
   assign m_last_o   = r_head_last;
   assign wait_cnt_o = r_wait_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
// ============================================================================
// Module   : tb_fifo_burst_reader
// Brief    : Directed vector table plus hand-written burst sequences for
//            fifo_burst_reader, driven from a simple FIFO model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_burst_reader;

   localparam int DATA_LEN = 32;
   localparam int BURST_W  = 8;
   localparam int WAIT_W   = 16;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                start_i;
   logic [BURST_W-1:0]  burst_len_i;
   logic                busy_o;
   logic                done_o;
   logic                rempty_i;
   logic [DATA_LEN-1:0] rdata_i;
   logic                rincr_o;
   logic [DATA_LEN-1:0] m_data_o;
   logic                m_last_o;
   logic                m_valid_o;
   logic                m_ready_i;
   logic [WAIT_W-1:0]   wait_cnt_o;

   always #5 clk = ~clk;

   fifo_burst_reader #(
      .DATA_LEN (DATA_LEN),
      .BURST_W  (BURST_W),
      .WAIT_W   (WAIT_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (start_i),
      .burst_len_i (burst_len_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .rempty_i    (rempty_i),
      .rdata_i     (rdata_i),
      .rincr_o     (rincr_o),
      .m_data_o    (m_data_o),
      .m_last_o    (m_last_o),
      .m_valid_o   (m_valid_o),
      .m_ready_i   (m_ready_i),
      .wait_cnt_o  (wait_cnt_o)
   );

   // FIFO model: data visible combinationally while not empty.
   logic [DATA_LEN-1:0] mem [0:31];
   logic [4:0]          rd_ptr = 5'd0;
   logic [4:0]          wr_ptr = 5'd0;

   assign rempty_i = (rd_ptr == wr_ptr);
   assign rdata_i  = mem[rd_ptr];

   always @(posedge clk) begin
      if (rincr_o && !rempty_i) rd_ptr <= rd_ptr + 5'd1;
   end

   typedef struct {
      logic        start;
      logic [7:0]  len;
      logic        ready;
      logic        rincr;
      logic        valid;
      logic        last;
      logic        done;
      logic        busy;
      logic        cdat;
      logic [31:0] data;
   } vec_t;

   vec_t vecs [0:10];

   int errors = 0;
   int checks = 0;

   logic [31:0] rx_d [0:15];
   logic        rx_l [0:15];
   int          rx_n;
   int          done_seen;
   logic [15:0] done_wait;
   logic        stall_prev;
   logic [31:0] prev_data;
   logic        prev_last;
   logic [4:0]  rp0;

   function automatic vec_t mk(input logic st, input logic [7:0] ln, input logic rd,
                               input logic ri, input logic v, input logic l, input logic d,
                               input logic b, input logic c, input logic [31:0] dat);
      vec_t t;
      t.start = st; t.len = ln; t.ready = rd; t.rincr = ri; t.valid = v;
      t.last = l; t.done = d; t.busy = b; t.cdat = c; t.data = dat;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%h want=%h", nm, got, want);
      end
   endtask

   task automatic push_word(input logic [31:0] d);
      mem[wr_ptr] = d;
      wr_ptr      = wr_ptr + 5'd1;
   endtask

   // Per-cycle stream monitor, called at the falling edge.
   task automatic sample();
      if (rincr_o) chk("pop_when_empty", {63'd0, rempty_i}, 64'd0);
      if (stall_prev) chk("stream_hold", {30'd0, m_valid_o, m_last_o, m_data_o},
                          {30'd0, 1'b1, prev_last, prev_data});
      if (m_valid_o && m_ready_i && rx_n < 16) begin
         rx_d[rx_n] = m_data_o;
         rx_l[rx_n] = m_last_o;
         rx_n++;
      end
      stall_prev = m_valid_o && !m_ready_i;
      prev_data  = m_data_o;
      prev_last  = m_last_o;
      if (done_o) begin
         done_seen++;
         done_wait = wait_cnt_o;
      end
   endtask

   task automatic finish_cycle();
      sample();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      @(negedge clk);
      finish_cycle();
   endtask

   task automatic begin_burst();
      rx_n       = 0;
      done_seen  = 0;
      stall_prev = 1'b0;
   endtask

   task automatic run_until_done(input int maxc);
      bit got = 1'b0;
      for (int i = 0; i < maxc && !got; i++) begin
         @(negedge clk);
         if (done_o) got = 1'b1;
         finish_cycle();
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL done_timeout got=no_done want=done within %0d cycles", maxc);
      end
   endtask

   task automatic check_rx(input string nm, input logic [31:0] base, input int n,
                           input logic [15:0] wexp);
      chk({nm, "_count"}, 64'(rx_n), 64'(n));
      for (int i = 0; i < n && i < rx_n; i++) begin
         chk($sformatf("%s_data%0d", nm, i), {32'd0, rx_d[i]}, {32'd0, base + 32'(i)});
         chk($sformatf("%s_last%0d", nm, i), {63'd0, rx_l[i]}, {63'd0, (i == n - 1)});
      end
      chk({nm, "_done_pulses"}, 64'(done_seen), 64'd1);
      chk({nm, "_wait"}, {48'd0, done_wait}, {48'd0, wexp});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n       = 1'b0;
      start_i     = 1'b0;
      burst_len_i = '0;
      m_ready_i   = 1'b0;
      begin_burst();
      for (int i = 0; i < 4; i++) push_word(32'hA0 + 32'(i));

      // Full-throughput 4-word burst, then a zero-length request.
      vecs[0]  = mk(1'b1, 8'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      vecs[1]  = mk(1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      vecs[2]  = mk(1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA0);
      vecs[3]  = mk(1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA1);
      vecs[4]  = mk(1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA2);
      vecs[5]  = mk(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA3);
      vecs[6]  = mk(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      vecs[7]  = mk(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      vecs[8]  = mk(1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      vecs[9]  = mk(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      vecs[10] = mk(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", {12'd0, busy_o, done_o, rincr_o, m_valid_o, m_last_o, m_data_o, wait_cnt_o},
          64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 11; i++) begin
         start_i     = vecs[i].start;
         burst_len_i = vecs[i].len;
         m_ready_i   = vecs[i].ready;
         @(negedge clk);
         chk($sformatf("vec%0d_flags", i), {59'd0, rincr_o, m_valid_o, done_o, busy_o, 1'b0},
             {59'd0, vecs[i].rincr, vecs[i].valid, vecs[i].done, vecs[i].busy, 1'b0});
         chk($sformatf("vec%0d_wait", i), {48'd0, wait_cnt_o}, 64'd0);
         if (vecs[i].cdat)
            chk($sformatf("vec%0d_data", i), {31'd0, m_last_o, m_data_o},
                {31'd0, vecs[i].last, vecs[i].data});
         finish_cycle();
      end
      start_i = 1'b0;

      // Backpressure: ready low for 3 cycles after the first word.
      for (int i = 0; i < 4; i++) push_word(32'hA0 + 32'(i));
      begin_burst();
      start_i = 1'b1; burst_len_i = 8'd4; m_ready_i = 1'b1;
      tick();
      start_i = 1'b0;
      tick();
      m_ready_i = 1'b0;
      @(negedge clk);
      chk("bp_first_word", {31'd0, m_valid_o, m_data_o}, {31'd0, 1'b1, 32'hA0});
      chk("bp_pop_c2", {63'd0, rincr_o}, 64'd1);
      finish_cycle();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk($sformatf("bp_full_nopop%0d", i), {63'd0, rincr_o}, 64'd0);
         chk($sformatf("bp_hold%0d", i), {32'd0, m_data_o}, 64'hA0);
         finish_cycle();
      end
      m_ready_i = 1'b1;
      run_until_done(20);
      check_rx("bp", 32'hA0, 4, 16'd0);

      // FIFO runs dry for 5 cycles after the second word.
      push_word(32'hB0);
      push_word(32'hB1);
      begin_burst();
      start_i = 1'b1; burst_len_i = 8'd6;
      tick();
      start_i = 1'b0;
      repeat (7) tick();
      for (int i = 2; i < 6; i++) push_word(32'hB0 + 32'(i));
      run_until_done(30);
      check_rx("empty", 32'hB0, 6, 16'd5);

      // A second start mid-burst is ignored.
      for (int i = 0; i < 6; i++) push_word(32'hC0 + 32'(i));
      begin_burst();
      start_i = 1'b1; burst_len_i = 8'd4;
      tick();
      start_i = 1'b0;
      tick();
      start_i = 1'b1; burst_len_i = 8'd2;
      tick();
      start_i = 1'b0;
      run_until_done(30);
      check_rx("restart", 32'hC0, 4, 16'd0);
      chk("restart_fifo_left", {59'd0, wr_ptr - rd_ptr}, 64'd2);
      begin_burst();
      start_i = 1'b1; burst_len_i = 8'd2;
      tick();
      start_i = 1'b0;
      run_until_done(20);
      check_rx("tail2", 32'hC4, 2, 16'd0);

      // Asynchronous reset mid-burst, then a clean burst.
      for (int i = 0; i < 6; i++) push_word(32'hD0 + 32'(i));
      rp0 = rd_ptr;
      begin_burst();
      start_i = 1'b1; burst_len_i = 8'd6;
      tick();
      start_i = 1'b0;
      repeat (2) tick();
      rst_n = 1'b0;
      #1;
      chk("midreset_outputs", {12'd0, busy_o, done_o, rincr_o, m_valid_o, m_last_o, m_data_o, wait_cnt_o},
          64'd0);
      stall_prev = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (3) tick();
      chk("midreset_pops", {59'd0, rd_ptr - rp0}, 64'd2);
      chk("midreset_idle", {62'd0, busy_o, done_o}, 64'd0);
      begin_burst();
      start_i = 1'b1; burst_len_i = 8'd4;
      tick();
      start_i = 1'b0;
      run_until_done(20);
      check_rx("postreset", 32'hD2, 4, 16'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Read-side consumer for the FIFO's read port, running in the read clock domain.
- On a start command it pops exactly burst_len words from the FIFO.
- Popped words go out on a valid/ready stream through a 2-entry skid buffer; the final word of the burst carries last.
- Reports busy/done and counts cycles stalled on FIFO empty.

Parameters:
- DATA_LEN, 32, FIFO word width and stream data width.
- BURST_W, 8, width of the burst-length field; max burst = 2^BURST_W-1.
- WAIT_W, 16, width of the empty-stall counter.

Ports:
- clk  in  1  read-domain clock.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  single-cycle burst request; sampled only in IDLE.
- burst_len_i  in  BURST_W  words to read; sampled with start_i.
- busy_o  out  1  high whenever state != IDLE.
- done_o  out  1  one-cycle pulse at burst completion.
- rempty_i  in  1  FIFO empty flag.
- rdata_i  in  DATA_LEN  FIFO read data, valid combinationally whenever rempty_i=0.
- rincr_o  out  1  FIFO pop strobe.
- m_data_o  out  DATA_LEN  stream data.
- m_last_o  out  1  marks the final word of the burst.
- m_valid_o  out  1  stream valid.
- m_ready_i  in  1  stream ready.
- wait_cnt_o  out  WAIT_W  cycles stalled on empty in the current or most recent burst.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; remaining=0; buffer count cnt=0.
  - All outputs 0: busy_o, done_o, rincr_o, m_valid_o, m_last_o, m_data_o, wait_cnt_o.
  - A reset mid-burst discards buffered words; no pops occur until the next start.
- States:
  - IDLE:
    - start_i=1 and burst_len_i!=0 -> RUN; remaining<=burst_len_i; wait_cnt<=0.
    - start_i=1 and burst_len_i=0 -> DONE; wait_cnt<=0.
  - RUN:
    - A pop that makes remaining 0 -> DRAIN.
    - If cnt==0 after that cycle, go directly -> DONE.
  - DRAIN:
    - cnt==1 and output handshake (no push) -> DONE.
  - DONE: done_o=1 for exactly one cycle -> IDLE.
- start_i outside IDLE is ignored; it does not change burst_len and does not queue.
- Pop rule: rincr_o = (state==RUN) & !rempty_i & (remaining!=0) & (cnt!=2).
  - Combinational from registered state and rempty_i.
  - Never asserted while empty.
- Each pop:
  - Writes {rdata_i, last=(remaining==1)} into the buffer.
  - Decrements remaining.
- Buffer: 2-entry FIFO of {data,last}.
  - m_valid_o = (cnt!=0); m_data_o/m_last_o come from the head register.
  - Handshake = m_valid_o & m_ready_i.
  - Same-cycle push and handshake keeps cnt unchanged (full throughput, 1 word/cycle).
  - Push when cnt=2 is impossible by the pop rule.
- Latency: a word popped in cycle N is on m_data_o in cycle N+1 (when it becomes head).
- Stream rule: while m_valid_o & !m_ready_i, m_data_o and m_last_o hold stable.
- done_o asserts the cycle after the handshake of the last-tagged word.
- wait_cnt:
  - Increments each cycle with state==RUN & remaining!=0 & rempty_i.
  - Saturates at all ones.
  - Holds its value after the burst until the next accepted start.
- Full throughput: with the FIFO never empty and m_ready_i=1, a burst of L words takes L pop cycles.
  - done_o pulses L+1 cycles after the first pop.

Test Plan:
- FIFO preloaded with 0xA0..0xA3; start_i with burst_len_i=4; m_ready_i=1:
  - rincr_o high for 4 consecutive cycles.
  - m_data_o shows A0,A1,A2,A3 on consecutive cycles, starting 1 cycle after the first pop.
  - m_last_o=1 only with A3; done_o is a single pulse the next cycle; wait_cnt_o=0.
- Same preload, m_ready_i held low for 3 cycles after the first word:
  - cnt reaches 2 and rincr_o drops.
  - m_data_o holds A0 stable.
  - After ready returns, all 4 words are delivered in order with no loss or duplication.
- burst_len_i=6, FIFO empty for 5 cycles after the 2nd word:
  - No rincr_o while rempty_i=1.
  - wait_cnt_o=5 at done.
  - Words 3..6 are delivered after data arrives.
- start_i with burst_len_i=0:
  - done_o pulses next cycle; rincr_o never asserts; m_valid_o stays 0.
- start_i pulsed again mid-burst:
  - Ignored; burst completes with the original length.
- rst_n=0 mid-burst:
  - All outputs 0 immediately; no pops afterwards.
  - A new start then runs a clean burst.
